// File: rtl/tiny_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and port indices.
package tiny_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA,
    ARB_RESP
  } arb_state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-pin bundle for the two-port memory arbiter.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 16
);

  logic             req0;
  logic             we0;
  logic             lock0;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;

  logic             req1;
  logic             we1;
  logic             lock1;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;

  logic [WIDTH-1:0] rdata;
  logic [1:0]       grant;

  logic             mem_mi;
  logic             mem_ri;
  logic [WIDTH-1:0] mem_wbus;
  logic [WIDTH-1:0] mem_rbus;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  mem_rbus,
    output ack0, ack1, rdata, grant, mem_mi, mem_ri, mem_wbus
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output mem_rbus,
    input  ack0, ack1, rdata, grant, mem_mi, mem_ri, mem_wbus
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational owner selection: bounded lock re-grant first, then round-robin.
module mem_arb_pick
  import tiny_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic [1:0]        req,
  input  logic              lock,
  input  logic              owner,
  input  logic              last,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              next_owner,
  output logic              valid,
  output logic              locked
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  always_comb begin
    valid      = |req;
    locked     = 1'b0;
    next_owner = last;
    if (lock && req[owner] && (hold_cnt < HOLD_LIMIT)) begin
      locked     = 1'b1;
      next_owner = owner;
    end else if (req == 2'b11) begin
      next_owner = ~last;
    end else begin
      next_owner = req[PORT_HOST];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sequencing the memory's MI (address) then RI/read (data) protocol.
module mem_port_arbiter
  import tiny_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int MAX_HOLD = 4,
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state_reg, state_next;
  logic              owner_reg;
  logic              last_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              cap_we_reg;
  logic [WIDTH-1:0]  cap_addr_reg;
  logic [WIDTH-1:0]  cap_wdata_reg;
  logic [WIDTH-1:0]  rdata_reg;

  logic        in_pick;
  logic        lock_owner;
  logic        pick_owner;
  logic        pick_valid;
  logic        pick_locked;
  logic        take;

  // Locking only means something at the end of an owned transaction.
  assign in_pick    = (state_reg == ARB_IDLE) || (state_reg == ARB_RESP);
  assign lock_owner = (state_reg == ARB_RESP) && (owner_reg ? bus.lock1 : bus.lock0);
  assign take       = in_pick && pick_valid;

  mem_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_pick (
    .req        ({bus.req1, bus.req0}),
    .lock       (lock_owner),
    .owner      (owner_reg),
    .last       (last_reg),
    .hold_cnt   (hold_cnt_reg),
    .next_owner (pick_owner),
    .valid      (pick_valid),
    .locked     (pick_locked)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= PORT_CPU;
      last_reg      <= PORT_HOST;
      hold_cnt_reg  <= '0;
      cap_we_reg    <= 1'b0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (in_pick) begin
        hold_cnt_reg <= pick_locked ? hold_cnt_reg + 1'b1 : '0;
      end
      if (take) begin
        owner_reg     <= pick_owner;
        last_reg      <= pick_owner;
        cap_we_reg    <= pick_owner ? bus.we1    : bus.we0;
        cap_addr_reg  <= pick_owner ? bus.addr1  : bus.addr0;
        cap_wdata_reg <= pick_owner ? bus.wdata1 : bus.wdata0;
      end
      if ((state_reg == ARB_DATA) && !cap_we_reg) begin
        rdata_reg <= bus.mem_rbus;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (pick_valid) state_next = ARB_ADDR;
      ARB_ADDR: state_next = ARB_DATA;
      ARB_DATA: state_next = ARB_RESP;
      ARB_RESP: state_next = pick_valid ? ARB_ADDR : ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  logic [1:0]       grant_c;
  logic             mi_c, ri_c, ack0_c, ack1_c;
  logic [WIDTH-1:0] wbus_c;

  always_comb begin
    grant_c = 2'b00;
    mi_c    = 1'b0;
    ri_c    = 1'b0;
    ack0_c  = 1'b0;
    ack1_c  = 1'b0;
    wbus_c  = '0;
    case (state_reg)
      ARB_ADDR: begin
        grant_c = {owner_reg, ~owner_reg};
        mi_c    = 1'b1;
        wbus_c  = cap_addr_reg;
      end
      ARB_DATA: begin
        grant_c = {owner_reg, ~owner_reg};
        ri_c    = cap_we_reg;
        wbus_c  = cap_we_reg ? cap_wdata_reg : cap_addr_reg;
      end
      ARB_RESP: begin
        grant_c = {owner_reg, ~owner_reg};
        ack0_c  = ~owner_reg;
        ack1_c  = owner_reg;
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_c;
  assign bus.mem_mi   = mi_c;
  assign bus.mem_ri   = ri_c;
  assign bus.mem_wbus = wbus_c;
  assign bus.ack0     = ack0_c;
  assign bus.ack1     = ack1_c;
  assign bus.rdata    = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a small two-step memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(8)) bus ();

  mem_port_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: MI latches the address, RI writes at the latched address.
  logic [7:0] ram [256];
  logic [7:0] addr_lat;
  always @(posedge clk) begin
    if (bus.mem_mi) addr_lat <= bus.mem_wbus;
    if (bus.mem_ri) ram[addr_lat] <= bus.mem_wbus;
  end
  assign bus.mem_rbus = ram[addr_lat];

  typedef struct {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic push(input logic port, input logic rd, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    sbq.push_back(e);
  endtask

  // Monitor: every ack pops one expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack0 && bus.ack1) begin
      check("ack_exclusive", 32'd1, 32'd0);
    end else if (bus.ack0 || bus.ack1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack_port", {31'd0, bus.ack1}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
        if (e.rd) check("ack_rdata", {24'd0, bus.rdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h05] = 8'h3C;
    ram[8'h20] = 8'h11;
    reset = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 0; bus.wdata1 = 0;

    cyc(2);
    check("reset_grant", {30'd0, bus.grant}, 32'd0);
    check("reset_mi_ri", {30'd0, bus.mem_mi, bus.mem_ri}, 32'd0);
    check("reset_wbus_rdata", {16'd0, bus.mem_wbus, bus.rdata}, 32'd0);
    reset = 1'b1;

    // Port 0 write 0x0A <- 0x55, then read it back.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h0A; bus.wdata0 = 8'h55;
    push(1'b0, 1'b0, 8'h00);
    cyc(1);
    check("t1_addr_mi", {31'd0, bus.mem_mi}, 32'd1);
    check("t1_addr_wbus", {24'd0, bus.mem_wbus}, 32'h0A);
    check("t1_addr_grant", {30'd0, bus.grant}, 32'd1);
    bus.req0 = 0; bus.addr0 = 8'hFF; bus.wdata0 = 8'h00;
    cyc(1);
    check("t1_data_ri", {31'd0, bus.mem_ri}, 32'd1);
    check("t1_data_wbus", {24'd0, bus.mem_wbus}, 32'h55);
    cyc(1);
    check("t1_ack0_cycle3", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h0A;
    push(1'b0, 1'b1, 8'h55);
    cyc(1);
    check("t1r_addr_wbus", {24'd0, bus.mem_wbus}, 32'h0A);
    bus.req0 = 0;
    cyc(1);
    check("t1r_data_ri", {31'd0, bus.mem_ri}, 32'd0);
    cyc(3);

    // Short req glitch in IDLE never sampled by a clock edge.
    bus.req0 = 1;
    #2 bus.req0 = 0;
    cyc(2);
    check("glitch_no_grant", {30'd0, bus.grant}, 32'd0);

    // Both requesters rise in the first cycle after reset release.
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h0A;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h05;
    push(1'b0, 1'b1, 8'h55);
    push(1'b1, 1'b1, 8'h3C);
    cyc(1);
    check("t2_grant_p0", {30'd0, bus.grant}, 32'd1);
    bus.req0 = 0;
    cyc(2);
    check("t2_ack0_cycle3", {31'd0, bus.ack0}, 32'd1);
    cyc(1);
    check("t2_grant_p1", {30'd0, bus.grant}, 32'd2);
    bus.req1 = 0;
    cyc(2);
    check("t2_ack1_cycle6", {31'd0, bus.ack1}, 32'd1);
    cyc(2);

    // Both held high, no locks: strict alternation with no idle cycle.
    bus.req0 = 1; bus.req1 = 1;
    push(1'b0, 1'b1, 8'h55);
    push(1'b1, 1'b1, 8'h3C);
    push(1'b0, 1'b1, 8'h55);
    push(1'b1, 1'b1, 8'h3C);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check($sformatf("t3_grant_c%0d", k), {30'd0, bus.grant},
            ((((k - 1) / 3) % 2) != 0) ? 32'd2 : 32'd1);
      if (k == 12) begin
        bus.req0 = 0; bus.req1 = 0;
      end
    end
    cyc(2);
    check("t3_idle_after", {30'd0, bus.grant}, 32'd0);

    // Port 1 locks; port 0 joins during the first transaction.
    bus.req1 = 1; bus.lock1 = 1; bus.we1 = 0; bus.addr1 = 8'h05;
    for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 8'h3C);
    push(1'b0, 1'b1, 8'h55);
    cyc(1);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h0A;
    cnt = 0;
    while (bus.grant != 2'b01 && cnt < 40) begin
      cnt++;
      cyc(1);
    end
    check("t4_p1_locked_cycles", cnt, 32'd15);
    check("t4_hold_cleared", {29'd0, dut.hold_cnt_reg}, 32'd0);
    bus.req0 = 0; bus.req1 = 0; bus.lock1 = 0;
    cyc(4);

    // Reset during DATA of a write to 0x20 aborts it.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 8'hAA;
    cyc(2);
    check("t5_data_ri", {31'd0, bus.mem_ri}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_rst_ri", {31'd0, bus.mem_ri}, 32'd0);
    check("t5_rst_grant", {30'd0, bus.grant}, 32'd0);
    bus.we0 = 0;
    cyc(2);
    reset = 1'b1;
    push(1'b0, 1'b1, 8'h11);
    cyc(1);
    check("t5_regrant_p0", {30'd0, bus.grant}, 32'd1);
    bus.req0 = 0;
    cyc(4);

    // One-cycle req1 read still completes.
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h05;
    push(1'b1, 1'b1, 8'h3C);
    cyc(1);
    bus.req1 = 0; bus.addr1 = 8'h00;
    cyc(5);

    cnt = 0;
    while (sbq.size() != 0 && cnt < 20) begin
      cnt++;
      cyc(1);
    end
    check("sb_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters. Port 0 is the CPU control path; port 1 is the host/program loader or debug agent.
- Sequences the memory's two-step protocol: assert MI with the address on the write bus, then either assert RI with the data (write) or sample the read bus (read).
- Sits between the requesters and the memory's MI, RI, write-bus and read-bus pins.
- Round-robin arbitration with an optional bounded lock for back-to-back ownership.

Parameters:
- WIDTH, 16: data/address width. Matches the memory WIDTH.
- MAX_HOLD, 4: maximum consecutive locked transactions granted to one owner while the other port is requesting. Must be ≥1.
- HOLD_W, $clog2(MAX_HOLD+1): width of the hold counter. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- req0  in  1  port 0 transaction request.
- we0  in  1  port 0: 1 = write, 0 = read.
- lock0  in  1  port 0 requests to keep ownership after this transaction.
- addr0  in  WIDTH  port 0 address.
- wdata0  in  WIDTH  port 0 write data.
- ack0  out  1  port 0 transaction complete; one-cycle pulse.
- req1, we1, lock1, addr1, wdata1, ack1: same signals for port 1.
- rdata  out  WIDTH  read data. Valid only in the cycle ackN=1 for a read.
- grant  out  2  one-hot current owner; 00 when idle.
- mem_mi  out  1  memory address-latch enable.
- mem_ri  out  1  memory write enable.
- mem_wbus  out  WIDTH  memory write bus (address or data).
- mem_rbus  in  WIDTH  memory combinational read bus.

Behaviour:

Reset (reset=0, asynchronous):
- state=IDLE; grant, ack0, ack1, mem_mi, mem_ri = 0; mem_wbus=0; rdata=0; hold counter=0.
- Last-served pointer=1, so port 0 wins the first tie.

FSM states: IDLE, ADDR, DATA, RESP.
- All memory controls, grant and ack are decoded from registered state. There is no combinational path from req* to mem_*.

Picking an owner (evaluated in IDLE and RESP):
- Only one port requesting: that port wins.
- Both requesting: the port not last served wins, subject to the lock rule below.

Capture:
- On the edge entering ADDR, the winner's we/addr/wdata are registered internally.
- Later changes on the requester inputs are ignored until its ack.

Cycle sequence:
- IDLE: outputs 0. If any req → ADDR.
- ADDR: grant=owner, mem_mi=1, mem_wbus=captured addr. → DATA.
- DATA, write: mem_ri=1, mem_wbus=captured wdata.
- DATA, read: mem_ri=0, mem_wbus=captured addr; rdata ← mem_rbus registered at the end of DATA.
- DATA → RESP.
- RESP: ack(owner)=1 for exactly one cycle. For reads, rdata is valid this cycle. Re-arbitrate: if any req → ADDR, else IDLE.

Latency and throughput:
- req sampled high in IDLE at edge n → ADDR in cycle n+1, DATA in n+2, ack in n+3.
- Back-to-back throughput: one transaction per 3 cycles.

Lock rule (evaluated in RESP):
- If owner's lock=1, owner's req=1, and hold counter < MAX_HOLD: the owner is granted again regardless of the other port; hold counter increments.
- Otherwise normal round-robin applies, and the hold counter clears whenever ownership changes or lock=0.
- A lone requester is never blocked by the hold limit.

Boundary conditions:
- req dropped after capture: the transaction completes and ack still pulses.
- req dropped while IDLE before being sampled: no transaction.
- Requester keeps req=1 through ack: treated as a new request in RESP.
- Simultaneous ack0 and ack1: impossible by construction.
- Reset mid-transaction (any state): all outputs clear immediately, with no ack and no RI. Memory contents written in earlier completed DATA cycles are retained.
- addr/wdata wrap: values pass through unmodified at WIDTH bits; there is no arithmetic on them.

Decomposition:
- Shared package tiny_pkg holds:
  - the arbiter state enum (ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RESP);
  - the port index constants PORT_CPU=0 and PORT_HOST=1.
- One sub-module, mem_arb_pick (combinational). Inputs: req[1:0], lock of owner, owner, last, hold_cnt, MAX_HOLD. Output: next owner plus a valid flag.
- FSM, capture registers and hold counter stay in mem_port_arbiter.

Test Plan:
1. Port 0 write addr=0x0A, wdata=0x55 from IDLE, WIDTH=8 → cycle+1: mem_mi=1, mem_wbus=0x0A, grant=01; cycle+2: mem_ri=1, mem_wbus=0x55; cycle+3: ack0=1. Then a port 0 read of 0x0A → ack0 with rdata=0x55.
2. req0 and req1 both rise in the first cycle after reset release → port 0 served first (ack0 at cycle 3), port 1 next (ack1 at cycle 6); grant sequence 01, 10.
3. Both held high with no locks for 12 cycles → grants alternate 0,1,0,1; exactly 4 acks, 2 per port; no idle cycle between transactions.
4. MAX_HOLD=4, lock1=1, req1 high continuously, req0 raised mid-stream → port 1 receives 4 consecutive locked grants after req0 rises, then port 0 is granted. Hold counter returns to 0.
5. reset driven low during DATA of a write to 0x20 with data 0xAA → mem_ri and grant drop immediately; no ack; ram[0x20] unchanged. After release, a pending req0 is granted first.
6. req1 asserted for one cycle in IDLE with we1=0, addr1=0x05 → full read completes; ack1 pulses once with rdata=contents of 0x05, even though req1 is already low.
